scan_readout: RTL and testbench



---
 rtl/scan_readout.sv | 108 ++++++++++
 tb/tb_scan_readout.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_readout.sv
// Debug scan readout: captures a parallel snapshot and streams it LSB first over a REQ/ACK/NEXT handshake.
// Optional even-parity trailer bit enabled by defining SCAN_READOUT_PARITY_EN.
module scan_readout #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             req,
    input  logic             next,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             busy,
    output logic             ack
);

`ifdef SCAN_READOUT_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]           state, state_d;
    logic [FRAME_LEN-1:0] sreg, sreg_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [FRAME_LEN-1:0] load_val;
    logic                 sdo_d, sdo_valid_d, busy_d, ack_d;

    // Frame image taken at capture; parity (when present) rides above the MSB.
`ifdef SCAN_READOUT_PARITY_EN
    assign load_val = {^data, data};
`else
    assign load_val = data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            cnt       <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            busy      <= 1'b0;
            ack       <= 1'b0;
        end else begin
            state     <= state_d;
            sreg      <= sreg_d;
            cnt       <= cnt_d;
            sdo       <= sdo_d;
            sdo_valid <= sdo_valid_d;
            busy      <= busy_d;
            ack       <= ack_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        cnt_d   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    sreg_d  = load_val;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!req) begin
                    // abort wins over a simultaneous strobe; partial frame is dropped
                    sreg_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (next) begin
                    sreg_d = sreg >> 1;
                    cnt_d  = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(FRAME_LEN - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!req) begin
                    sreg_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                sreg_d  = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        sdo_valid_d = (state_d == ST_SHIFT);
        busy_d      = (state_d == ST_SHIFT);
        ack_d       = (state_d == ST_DONE);
        sdo_d       = (state_d == ST_SHIFT) ? sreg_d[0] : 1'b0;
    end

endmodule

// File: tb/tb_scan_readout.sv
// Scoreboard bench for scan_readout (WIDTH=8): stimulus pushes expected frame bits, a negedge monitor pops on each consumed bit.
module tb_scan_readout;

    localparam int unsigned WIDTH = 8;
`ifdef SCAN_READOUT_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data;
    logic             req;
    logic             next;
    logic             sdo;
    logic             sdo_valid;
    logic             busy;
    logic             ack;

    int   vectors;
    int   miscompares;
    bit   exp_q[$];
    logic ack_prev;

    scan_readout #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .req       (req),
        .next      (next),
        .sdo       (sdo),
        .sdo_valid (sdo_valid),
        .busy      (busy),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: data bits LSB first, then even parity when enabled.
    task automatic push_frame(input logic [WIDTH-1:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            exp_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (FRAME_LEN > WIDTH) exp_q.push_back(bit'(ones % 2));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame(input logic [WIDTH-1:0] d);
        data = d;
        req  = 1'b1;
        push_frame(d);
        tick();
        check("capture_busy", 64'(busy), 64'd1);
        check("capture_sdo", 64'(sdo), 64'(d[0]));
    endtask

    task automatic shift_bits(input int n, input int gap);
        logic s;
        for (int i = 0; i < n; i++) begin
            next = 1'b1;
            tick();
            next = 1'b0;
            s = sdo;
            for (int g = 0; g < gap; g++) begin
                tick();
                check("sdo_hold", 64'(sdo), 64'(s));
            end
        end
    endtask

    task automatic expect_done();
        check("done_ack", 64'(ack), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_valid", 64'(sdo_valid), 64'd0);
        check("frame_consumed", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic release_req();
        req = 1'b0;
        tick();
        check("release_ack", 64'(ack), 64'd0);
    endtask

    // Monitor: a bit is consumed when NEXT is sampled with REQ high while SDO is valid.
    always @(negedge clk) begin
        if (!rst && req && next && sdo_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sdo_underflow: got bit %0b expected none at %0t", sdo, $time);
            end else begin
                check("sdo_bit", 64'(sdo), 64'(exp_q.pop_front()));
            end
        end
        if (!rst && ack && !ack_prev) begin
            check("ack_rise_q_empty", 64'(exp_q.size()), 64'd0);
        end
        ack_prev = ack;
    end

    initial begin
        logic [WIDTH-1:0] d;
        vectors     = 0;
        miscompares = 0;
        ack_prev    = 1'b0;
        rst  = 1'b1;
        data = '0;
        req  = 1'b0;
        next = 1'b0;
        tick();
        tick();
        check("rst_sdo", 64'(sdo), 64'd0);
        check("rst_valid", 64'(sdo_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        rst = 1'b0;
        tick();

        // Reset mid-frame, asynchronous clear, then fresh capture.
        start_frame(8'hA5);
        shift_bits(2, 0);
        rst = 1'b1;
        #1;
        check("arst_sdo", 64'(sdo), 64'd0);
        check("arst_valid", 64'(sdo_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_ack", 64'(ack), 64'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        push_frame(8'hA5);
        tick();
        check("post_rst_sdo", 64'(sdo), 64'd1);
        check("post_rst_valid", 64'(sdo_valid), 64'd1);
        shift_bits(FRAME_LEN, 0);
        expect_done();
        release_req();

        // Basic frame and parity-odd frame at full rate.
        start_frame(8'hA5);
        shift_bits(FRAME_LEN, 0);
        expect_done();
        release_req();
        start_frame(8'h07);
        shift_bits(FRAME_LEN - 1, 0);
        check("pre_last_ack", 64'(ack), 64'd0);
        shift_bits(1, 0);
        expect_done();
        release_req();

        // Capture isolation with sparse strobes.
        start_frame(8'hA5);
        data = 8'hFF;
        shift_bits(FRAME_LEN, 3);
        expect_done();
        release_req();

        // Abort after 3 bits with a coincident strobe.
        start_frame(8'h3C);
        shift_bits(3, 0);
        req  = 1'b0;
        next = 1'b1;
        tick();
        next = 1'b0;
        exp_q.delete();
        check("abort_ack", 64'(ack), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(sdo_valid), 64'd0);
        tick();
        tick();
        check("abort_ack_stays0", 64'(ack), 64'd0);
        start_frame(8'hC9);
        shift_bits(FRAME_LEN, 0);
        expect_done();

        // Handshake hold: REQ stays high after ACK, strobes ignored.
        for (int i = 0; i < 5; i++) begin
            next = 1'(i % 2);
            tick();
            check("hold_ack", 64'(ack), 64'd1);
            check("hold_busy", 64'(busy), 64'd0);
        end
        next = 1'b0;
        release_req();
        start_frame(8'h5A);
        shift_bits(FRAME_LEN, 0);
        expect_done();
        release_req();

        // Randomized frames with random strobe gaps.
        for (int f = 0; f < 20; f++) begin
            d = WIDTH'($urandom);
            start_frame(d);
            data = WIDTH'($urandom);
            for (int b = 0; b < int'(FRAME_LEN); b++) begin
                shift_bits(1, int'($urandom_range(0, 2)));
            end
            expect_done();
            release_req();
        end

        check("final_q_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
